// File: rtl/line_scanner.sv
// line_scanner: fetches one line from the frame store, then serializes it one
// pixel per accepted cycle with coordinates and horizontal/vertical sync.
// Optional feature macro: LINE_SCANNER_TESTPAT_EN adds the testMode port and
// a coordinate-derived test pattern that replaces the frame store fetch.
module line_scanner #(
  parameter int unsigned PX_PER_LINE = 330,
  parameter int unsigned LINES       = 110,
  parameter int unsigned HBLANK      = 16,
  parameter int unsigned HSYNC_W     = 4,
  parameter int unsigned VBLANK      = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [0:PX_PER_LINE*8-1]   LineData,
  output logic                       readFrame,
  input  logic                       PxReady,
  output logic [7:0]                 PxData,
  output logic                       PxValid,
  output logic [9:0]                 PxOut,
  output logic [9:0]                 LineOut,
  output logic                       HSync,
  output logic                       VSync,
`ifdef LINE_SCANNER_TESTPAT_EN
  input  logic                       testMode,
`endif
  output logic                       FrameDone
);

  localparam int unsigned LW    = PX_PER_LINE * 8;
  localparam int unsigned IW    = $clog2(LW);
  localparam int unsigned BMAX  = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int unsigned BW    = $clog2(BMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_ACTIVE = 3'd3,
    S_HBL    = 3'd4,
    S_VBL    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [0:LW-1]   line_q, line_d;
  logic [7:0]      px_data_q, px_data_d;
  logic            px_valid_q, px_valid_d;
  logic [9:0]      px_out_q, px_out_d;
  logic [9:0]      line_out_q, line_out_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            frame_done_q, frame_done_d;
  logic            read_frame_q, read_frame_d;
  logic [BW-1:0]   bl_q, bl_d;
  logic            tpat_q, tpat_d;

  logic            accept_c;
  logic            last_px_c;
  logic            hbl_end_c;
  logic            vbl_end_c;
  logic [9:0]      px_inc_c;
  logic [IW-1:0]   px_idx_c;

  assign accept_c  = px_valid_q && PxReady;
  assign last_px_c = (px_out_q == 10'(PX_PER_LINE - 1));
  assign hbl_end_c = (bl_q == BW'(HBLANK - 1));
  assign vbl_end_c = (bl_q == BW'(VBLANK - 1));
  assign px_inc_c  = px_out_q + 10'd1;
  assign px_idx_c  = IW'({px_inc_c, 3'b000});

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: raster sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_LOAD;
      S_LOAD:   state_d = S_ACTIVE;
      S_ACTIVE: if (accept_c && last_px_c) state_d = S_HBL;
      S_HBL:    if (hbl_end_c) state_d = (line_out_q < 10'(LINES - 1)) ? S_FETCH : S_VBL;
      S_VBL:    if (vbl_end_c) state_d = run ? S_FETCH : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; every output is registered from these
  always_comb begin
    line_d       = line_q;
    px_data_d    = px_data_q;
    px_out_d     = px_out_q;
    line_out_d   = line_out_q;
    tpat_d       = tpat_q;
    bl_d         = '0;
    read_frame_d = 1'b0;

    // Test-pattern mode is latched once per line as the fetch is issued
    if (state_d == S_FETCH) begin
`ifdef LINE_SCANNER_TESTPAT_EN
      tpat_d       = testMode;
      read_frame_d = !testMode;
`else
      tpat_d       = 1'b0;
      read_frame_d = 1'b1;
`endif
    end

    if ((state_q == S_HBL || state_q == S_VBL) && state_d == state_q) begin
      bl_d = bl_q + BW'(1);
    end

    case (state_q)
      S_IDLE: line_out_d = '0;
      S_LOAD: begin
        px_out_d = '0;
        if (tpat_q) begin
          px_data_d = {line_out_q[2:0], 5'd0};
        end else begin
          line_d    = LineData;
          px_data_d = LineData[0 +: 8];
        end
      end
      S_ACTIVE: begin
        if (accept_c && !last_px_c) begin
          px_out_d  = px_inc_c;
          px_data_d = tpat_q ? {line_out_q[2:0], px_inc_c[4:0]} : line_q[px_idx_c +: 8];
        end
      end
      S_HBL: if (hbl_end_c && state_d == S_FETCH) line_out_d = line_out_q + 10'd1;
      S_VBL: if (vbl_end_c) line_out_d = '0;
      default: ;
    endcase

    px_valid_d   = (state_d == S_ACTIVE);
    hsync_d      = (state_d == S_HBL) && (bl_d < BW'(HSYNC_W));
    vsync_d      = (state_d == S_VBL);
    frame_done_d = (state_d == S_VBL) && (bl_d == BW'(VBLANK - 1));
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_q       <= '0;
      px_data_q    <= '0;
      px_valid_q   <= 1'b0;
      px_out_q     <= '0;
      line_out_q   <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
      read_frame_q <= 1'b0;
      bl_q         <= '0;
      tpat_q       <= 1'b0;
    end else begin
      line_q       <= line_d;
      px_data_q    <= px_data_d;
      px_valid_q   <= px_valid_d;
      px_out_q     <= px_out_d;
      line_out_q   <= line_out_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_done_q <= frame_done_d;
      read_frame_q <= read_frame_d;
      bl_q         <= bl_d;
      tpat_q       <= tpat_d;
    end
  end

  assign readFrame = read_frame_q;
  assign PxData    = px_data_q;
  assign PxValid   = px_valid_q;
  assign PxOut     = px_out_q;
  assign LineOut   = line_out_q;
  assign HSync     = hsync_q;
  assign VSync     = vsync_q;
  assign FrameDone = frame_done_q;

endmodule

// File: doc/line_scanner.md
# line_scanner

Downstream display stage of the frame store. Fetches one 2640-bit line (330 pixels × 8 bits) at a time through the frame store's `readFrame`/`FrameDataOut` interface, then serializes it one pixel per accepted cycle with pixel/line coordinates and horizontal/vertical sync. It generates the raster for the 330 × 110 frame and drives the panel-side pixel interface.

## Interface
- `PX_PER_LINE`, 330: pixels per line; line word width is `PX_PER_LINE*8`.
- `LINES`, 110: active lines per frame.
- `HBLANK`, 16: blanking cycles after each line; must be ≥ 3.
- `HSYNC_W`, 4: `HSync` high cycles at the start of `HBLANK`; must be ≤ `HBLANK`.
- `VBLANK`, 64: cycles after the last line's `HBLANK`, with `VSync` high throughout.

Ports:
- `clk`  in  1: single clock; rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `run`  in  1: level; while high, frames repeat; sampled in IDLE and at end of VBLANK.
- `LineData`  in  [0:2639]: line word from the frame store; pixel k = `LineData[8k:8k+7]`.
- `readFrame`  out  1: one-cycle line-fetch strobe to the frame store.
- `PxReady`  in  1: sink accepts the pixel when `PxValid && PxReady`.
- `PxData`  out  8: current pixel.
- `PxValid`  out  1: `PxData`, `PxOut`, `LineOut` valid.
- `PxOut`  out  10: pixel index within line, 0..`PX_PER_LINE-1`.
- `LineOut`  out  10: line index, 0..`LINES-1`.
- `HSync`  out  1: horizontal sync.
- `VSync`  out  1: vertical sync.
- `FrameDone`  out  1: one-cycle pulse on the last VBLANK cycle.
- `testMode`  in  1: present only with `LINE_SCANNER_TESTPAT_EN`.

## Operation
- States: IDLE, FETCH, LOAD, ACTIVE, HBL, VBL.
- **IDLE:** `run`=1 → FETCH with `LineOut`=0.
- **FETCH:** `readFrame`=1 for exactly one cycle → LOAD.
- **LOAD:** capture `LineData` into the internal line register; `PxOut`=0 → ACTIVE.
- **ACTIVE:** `PxValid`=1, `PxData` = pixel `PxOut` of the line register.
  - On accept: if `PxOut`=`PX_PER_LINE-1` → HBL, else `PxOut`+1.
  - `PxReady`=0 holds all outputs unchanged; no pixel is dropped or repeated.
- **HBL:** `PxValid`=0; `HSync`=1 for the first `HSYNC_W` cycles; lasts `HBLANK` cycles.
  - Exit when `LineOut`<`LINES-1`: `LineOut`+1 → FETCH.
  - Exit otherwise: → VBL.
- **VBL:** `VSync`=1 for `VBLANK` cycles; `FrameDone` pulses on the last cycle.
  - On exit, `LineOut`=0; `run`=1 → FETCH, else IDLE.
- `run` falling mid-frame has no effect; the current frame completes.
- Counters wrap only by explicit reload; no arithmetic overflow is possible for legal parameters.

## Timing
- Reset (async assert, synchronous-release-safe) sets: state IDLE, `readFrame`=0, `PxValid`=0, `PxData`=0, `PxOut`=0, `LineOut`=0, `HSync`=0, `VSync`=0, `FrameDone`=0, and clears the line register.
- Frame store latency is one cycle: `readFrame` high in cycle N, `LineData` valid in N+1 and captured at the end of N+1.
- First pixel of a line is valid in cycle N+2 after FETCH.
- With `PxReady` held high, one line = 2 + `PX_PER_LINE` + `HBLANK` cycles (348 by default).
- With `PxReady` held high, one frame = 110 × 348 + 64 = 38344 cycles.
- All outputs are registered.
- `readFrame` is never high outside FETCH.
- Reset asserted mid-line aborts immediately; the next line after release is line 0.

## Configuration
- `LINE_SCANNER_TESTPAT_EN` defined:
  - Adds the `testMode` port.
  - When `testMode`=1 is sampled at FETCH, `readFrame` is suppressed for that line.
  - `PxData` becomes `{LineOut[2:0], PxOut[4:0]}` for that line; timing is identical.
- Macro undefined: no `testMode` port; `PxData` always comes from `LineData`.

## Test plan
- **Single line:**
  - Stimulus: release reset, `run`=1, `PxReady`=1, `LineData` pixel k = k mod 256.
  - Response: `readFrame` at cycle 1, `PxValid` cycles 3..332, `PxData` 0..255,0..73, `PxOut` 0..329.
- **Backpressure:**
  - Stimulus: `PxReady` low at pixels 5, 100 and 329 for 3 cycles each.
  - Response: outputs frozen during each stall; 330 accepts total; line time extends by 9 cycles.
- **Frame boundary:**
  - Stimulus: full frame with `PxReady`=1.
  - Response: `LineOut` 0..109; `HSync` 4 cycles per line; `VSync` 64 cycles; `FrameDone` pulse at cycle 38344.
  - Response, continued: `run`=1 restarts at `LineOut`=0.
- **Stop:**
  - Stimulus: `run` dropped at line 50.
  - Response: frame completes to `FrameDone`, then IDLE; no further `readFrame`.
- **Mid-operation reset:**
  - Stimulus: reset asserted during ACTIVE at pixel 200 of line 7.
  - Response: all outputs 0 immediately; after release, restart fetches line 0.
- **Test pattern** (with `LINE_SCANNER_TESTPAT_EN`):
  - Stimulus: `testMode`=1.
  - Response: no `readFrame`; line 3 pixel 17 = 8'h71.
